// File: rtl/masked_table_bram_if.sv
// masked_table_bram_if: load-stream, read-port and status bundle of the masked S-box table
interface masked_table_bram_if #(parameter int DATA_W = 8, parameter int ADDR_W = 10);
  logic              EN;
  logic              ld_start;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              tbl_ready;
  logic              rd_valid_a;
  logic [ADDR_W-1:0] addr_a;
  logic              rd_valid_b;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] dout_a;
  logic              dout_valid_a;
  logic [DATA_W-1:0] dout_b;
  logic              dout_valid_b;
  logic              rd_err;
  modport master (
    output EN, ld_start, ld_valid, ld_data, rd_valid_a, addr_a, rd_valid_b, addr_b,
    input  ld_ready, tbl_ready, dout_a, dout_valid_a, dout_b, dout_valid_b, rd_err
  );
  modport slave (
    input  EN, ld_start, ld_valid, ld_data, rd_valid_a, addr_a, rd_valid_b, addr_b,
    output ld_ready, tbl_ready, dout_a, dout_valid_a, dout_b, dout_valid_b, rd_err
  );
endinterface

// File: rtl/masked_table_bram.sv
// masked_table_bram: run-time loadable dual-read-port S-box table in inferred block RAM
module masked_table_bram #(
  parameter int              DATA_W  = 8,
  parameter int              ADDR_W  = 10,
  parameter int              OUT_REG = 1,
  parameter logic [DATA_W-1:0] SRVAL = '0
) (
  input logic clk,
  input logic rst,
  masked_table_bram_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, port_a_addr;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] d1_a_q, d1_b_q, d2_a_q, d2_a_d, d2_b_q, d2_b_d;
  logic              v1_a_q, v1_a_d, v1_b_q, v1_b_d, v2_a_q, v2_a_d, v2_b_q, v2_b_d;
  logic              err_q, err_d, wr, acc_a, acc_b;
  always_comb begin
    wr          = bus.EN && state_q == LOAD && bus.ld_valid && !bus.ld_start;
    acc_a       = bus.EN && bus.rd_valid_a && state_q == READY;
    acc_b       = bus.EN && bus.rd_valid_b && state_q == READY;
    port_a_addr = state_q == LOAD ? cnt_q : bus.addr_a;
    cnt_d       = (bus.EN && bus.ld_start) ? '0 : wr ? cnt_q + 1'b1 : cnt_q;
    state_d     = (bus.EN && bus.ld_start) ? LOAD : (wr && &cnt_q) ? READY : state_q;
    err_d       = bus.EN && state_q != READY && (bus.rd_valid_a || bus.rd_valid_b);
    v1_a_d      = bus.EN ? acc_a : v1_a_q;
    v1_b_d      = bus.EN ? acc_b : v1_b_q;
    v2_a_d      = bus.EN ? v1_a_q : v2_a_q;
    v2_b_d      = bus.EN ? v1_b_q : v2_b_q;
    d2_a_d      = (bus.EN && v1_a_q) ? d1_a_q : d2_a_q;
    d2_b_d      = (bus.EN && v1_b_q) ? d1_b_q : d2_b_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      v1_a_q  <= 1'b0;
      v1_b_q  <= 1'b0;
      v2_a_q  <= 1'b0;
      v2_b_q  <= 1'b0;
      d2_a_q  <= SRVAL;
      d2_b_q  <= SRVAL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      v1_a_q  <= v1_a_d;
      v1_b_q  <= v1_b_d;
      v2_a_q  <= v2_a_d;
      v2_b_q  <= v2_b_d;
      d2_a_q  <= d2_a_d;
      d2_b_q  <= d2_b_d;
    end
  end
  // Port A carries the load write in LOAD; reads only happen in READY so the ports never collide.
  always_ff @(posedge clk) begin
    if (wr) mem[port_a_addr] <= bus.ld_data;
  end
  always_ff @(posedge clk) begin
    if (rst) d1_a_q <= SRVAL;
    else if (acc_a) d1_a_q <= mem[port_a_addr];
  end
  always_ff @(posedge clk) begin
    if (rst) d1_b_q <= SRVAL;
    else if (acc_b) d1_b_q <= mem[bus.addr_b];
  end
  assign bus.ld_ready     = state_q == LOAD;
  assign bus.tbl_ready    = state_q == READY;
  assign bus.rd_err       = err_q;
  assign bus.dout_a       = OUT_REG != 0 ? d2_a_q : d1_a_q;
  assign bus.dout_b       = OUT_REG != 0 ? d2_b_q : d1_b_q;
  assign bus.dout_valid_a = OUT_REG != 0 ? v2_a_q : v1_a_q;
  assign bus.dout_valid_b = OUT_REG != 0 ? v2_b_q : v1_b_q;
endmodule
